// File: rtl/fft_pkg.sv
// Shared types for the FFT streaming sequencer: FSM states, complex bin layout
// and the frame-length helper.
package fft_pkg;

  typedef enum logic [2:0] {
    LOAD,
    START,
    WAIT,
    CAPTURE,
    HOLD
  } state_t;

  localparam int CPLX_W = 16;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  function automatic int frame_len(input int n2);
    return 1 << n2;
  endfunction

endpackage

// File: rtl/fft_stream_sequencer_if.sv
// Valid/ready sample input stream and bin output stream of the sequencer.
interface fft_stream_sequencer_if #(
  parameter int WIDTH = 16
);
  logic               s_valid;
  logic               s_ready;
  logic [WIDTH-1:0]   s_data;
  logic               m_valid;
  logic               m_ready;
  logic [2*WIDTH-1:0] m_data;
  logic               m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fft_frame_buf.sv
// One-frame dual-port buffer between the core's result burst and the output
// stream; capture writes and downstream reads proceed independently.
module fft_frame_buf
  import fft_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N_2   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [2*WIDTH-1:0] wr_data,
  input  logic               rd_en,
  output logic [2*WIDTH-1:0] rd_data,
  output logic [N_2-1:0]     rd_ptr,
  output logic               empty
);
  localparam int N = frame_len(N_2);
  localparam logic [N_2:0] FULL_CNT = (N_2+1)'(N);

  logic [2*WIDTH-1:0] mem [N];
  logic [N_2-1:0]     wr_ptr;
  logic [N_2:0]       count;
  logic               full;
  logic               push;
  logic               pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at N; clear drops the whole frame in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fft_stream_sequencer.sv
// Feeds sample frames into the fft core and streams its result bins out,
// holding the next start until the previous frame has fully drained.
module fft_stream_sequencer
  import fft_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N_2   = 5,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   abort,
  fft_stream_sequencer_if.slave  strm,
  output logic                   fft_load,
  output logic [N_2-1:0]         fft_adr,
  output logic [WIDTH-1:0]       fft_rd,
  output logic                   fft_start,
  input  logic [2*WIDTH-1:0]     fft_wd,
  input  logic                   fft_done,
  output logic [CNT_W-1:0]       frame_count,
  output logic                   busy
);
  localparam logic [N_2-1:0] LAST_IDX = N_2'(frame_len(N_2) - 1);

  state_t         state, next_state;
  logic [N_2-1:0] load_idx;
  logic [N_2-1:0] cap_idx;
  logic           load_inc;
  logic           cap_wr;
  logic           start_c;
  logic           ready_c;
  logic           buf_empty;
  logic [N_2-1:0] rd_ptr;
  logic           out_fire;

  fft_frame_buf #(.WIDTH(WIDTH), .N_2(N_2)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clear   (abort),
    .wr_en   (cap_wr),
    .wr_data (fft_wd),
    .rd_en   (strm.m_ready),
    .rd_data (strm.m_data),
    .rd_ptr  (rd_ptr),
    .empty   (buf_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= next_state;
  end

  // Abort overrides every transition and suppresses any strobe in its cycle.
  always_comb begin
    next_state = state;
    load_inc   = 1'b0;
    cap_wr     = 1'b0;
    start_c    = 1'b0;
    ready_c    = 1'b0;
    case (state)
      LOAD: begin
        ready_c = 1'b1;
        if (strm.s_valid) begin
          load_inc = 1'b1;
          if (load_idx == LAST_IDX) next_state = buf_empty ? START : HOLD;
        end
      end
      HOLD:    if (buf_empty) next_state = START;
      START: begin
        start_c    = 1'b1;
        next_state = WAIT;
      end
      WAIT: if (fft_done) begin
        cap_wr     = 1'b1;
        next_state = CAPTURE;
      end
      CAPTURE: if (fft_done) begin
        cap_wr = 1'b1;
        if (cap_idx == LAST_IDX) next_state = LOAD;
      end
      default: next_state = LOAD;
    endcase
    if (abort) begin
      next_state = LOAD;
      load_inc   = 1'b0;
      cap_wr     = 1'b0;
      start_c    = 1'b0;
      ready_c    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_idx    <= '0;
      cap_idx     <= '0;
      frame_count <= '0;
    end else begin
      if (abort)         load_idx <= '0;
      else if (load_inc) load_idx <= load_idx + 1'b1;
      if (abort)       cap_idx <= '0;
      else if (cap_wr) cap_idx <= cap_idx + 1'b1;
      if (out_fire && strm.m_last) frame_count <= frame_count + 1'b1;
    end
  end

  assign strm.s_ready = ready_c;
  assign fft_load     = ready_c && strm.s_valid;
  assign fft_adr      = load_idx;
  assign fft_rd       = fft_load ? strm.s_data : '0;
  assign fft_start    = start_c;

  assign strm.m_valid = !buf_empty;
  assign strm.m_last  = !buf_empty && (rd_ptr == LAST_IDX);
  assign out_fire     = strm.m_valid && strm.m_ready;

  assign busy = !((state == LOAD) && (load_idx == '0) && buf_empty);

endmodule
